// File: rtl/bram_rd_ctrl_pkg.sv
// Shared types and constants for the BRAM read controller: FSM encoding,
// access-type codes and the tag carried alongside in-flight reads.
package bram_rd_ctrl_pkg;

   localparam int   AW_DEFAULT = 13;
   localparam int   N_WORDS    = 16;
   localparam int   IDX_W      = 4;

   localparam logic ACC_512 = 1'b0;
   localparam logic ACC_32  = 1'b1;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_DRAIN = 2'd2,
      ST_HOLD  = 2'd3
   } state_e;

   typedef struct packed {
      logic             vld;
      logic [IDX_W-1:0] idx;
      logic             port;
   } lat_tag_t;

endpackage

// File: rtl/bram_rd_ctrl_lat_pipe.sv
// Delay line matching the BRAM read latency; tags each returning word with
// its slot index and requesting port.
module rd_lat_pipe
   import bram_rd_ctrl_pkg::*;
#(
   parameter int RD_LAT = 2
) (
   input  logic     i_clk,
   input  logic     i_rstn,
   input  lat_tag_t tag_i,
   output lat_tag_t tag_o
);

   lat_tag_t stage_q [RD_LAT];

   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         for (int i = 0; i < RD_LAT; i++) begin
            stage_q[i] <= '0;
         end
      end else begin
         stage_q[0] <= tag_i;
         for (int i = 1; i < RD_LAT; i++) begin
            stage_q[i] <= stage_q[i-1];
         end
      end
   end

   assign tag_o = stage_q[RD_LAT-1];

endmodule

// File: rtl/bram_rd_ctrl.sv
// Arbitrates a 32b single-word and a 512b 16-word requester onto one BRAM
// read port, assembles the returned data and holds it until released.
module bram_rd_ctrl
   import bram_rd_ctrl_pkg::*;
#(
   parameter int RD_LAT = 2,
   parameter int AW     = AW_DEFAULT
) (
   input  logic          i_clk,
   input  logic          i_rstn,
   input  logic          i_s_access_type,
   input  logic [AW-1:0] i_s_rd_addr,
   input  logic          i_s_rd_addr_ready,
   output logic          o_s_data_valid,
   output logic [31:0]   o_s_data,
   input  logic [AW-1:0] i_w_rd_addr,
   input  logic          i_w_rd_addr_ready,
   output logic          o_w_data_valid,
   output logic [511:0]  o_w_data,
   output logic          o_bram_en,
   output logic [AW-1:0] o_bram_addr,
   input  logic [31:0]   i_bram_dout
);

   state_e                    state_q, state_d;
   logic                      port_q;
   logic                      last_grant_q;
   logic                      abort_q;
   logic [IDX_W-1:0]          cnt_q;
   logic [AW-1:0]             addr_q;
   logic [31:0]               s_data_q;
   logic [N_WORDS-1:0][31:0]  w_data_q;

   logic     s_req, w_req, grant_s, grant_w, grant_any;
   logic     granted_ready, last_issue, last_cap;
   lat_tag_t issue_tag, ret_tag;
   logic     unused_w_lsb;

   // Low nibble of the wide address is forced to zero by design.
   assign unused_w_lsb = ^i_w_rd_addr[IDX_W-1:0];

   assign s_req     = i_s_rd_addr_ready && (i_s_access_type == ACC_32);
   assign w_req     = i_w_rd_addr_ready;
   assign grant_s   = s_req && (!w_req || (last_grant_q == ACC_512));
   assign grant_w   = w_req && (!s_req || (last_grant_q == ACC_32));
   assign grant_any = grant_s || grant_w;

   assign granted_ready = (port_q == ACC_32) ? i_s_rd_addr_ready : i_w_rd_addr_ready;
   assign last_issue    = (port_q == ACC_32) || (cnt_q == IDX_W'(N_WORDS - 1));
   assign last_cap      = ret_tag.vld &&
                          ((ret_tag.port == ACC_32) || (ret_tag.idx == IDX_W'(N_WORDS - 1)));

   assign issue_tag.vld  = (state_q == ST_ISSUE);
   assign issue_tag.idx  = cnt_q;
   assign issue_tag.port = port_q;

   rd_lat_pipe #(
      .RD_LAT (RD_LAT)
   ) u_lat_pipe (
      .i_clk  (i_clk),
      .i_rstn (i_rstn),
      .tag_i  (issue_tag),
      .tag_o  (ret_tag)
   );

   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE:  if (grant_any)      state_d = ST_ISSUE;
         ST_ISSUE: if (last_issue)     state_d = ST_DRAIN;
         ST_DRAIN: if (last_cap)       state_d = (abort_q || !granted_ready) ? ST_IDLE : ST_HOLD;
         ST_HOLD:  if (!granted_ready) state_d = ST_IDLE;
         default:                      state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      o_bram_en      = 1'b0;
      o_bram_addr    = '0;
      o_s_data_valid = 1'b0;
      o_w_data_valid = 1'b0;
      if (state_q == ST_ISSUE) begin
         o_bram_en   = 1'b1;
         o_bram_addr = (port_q == ACC_32) ? addr_q : {addr_q[AW-1:IDX_W], cnt_q};
      end
      if (state_q == ST_HOLD) begin
         o_s_data_valid = (port_q == ACC_32);
         o_w_data_valid = (port_q == ACC_512);
      end
   end

   assign o_s_data = s_data_q;
   assign o_w_data = w_data_q;

   // Data keeps landing after an abandoned request so the delay line drains cleanly.
   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         port_q       <= ACC_512;
         last_grant_q <= ACC_512;
         abort_q      <= 1'b0;
         cnt_q        <= '0;
         addr_q       <= '0;
         s_data_q     <= '0;
         w_data_q     <= '0;
      end else begin
         if ((state_q == ST_IDLE) && grant_any) begin
            port_q       <= grant_s ? ACC_32 : ACC_512;
            last_grant_q <= grant_s ? ACC_32 : ACC_512;
            abort_q      <= 1'b0;
            cnt_q        <= '0;
            addr_q       <= grant_s ? i_s_rd_addr : {i_w_rd_addr[AW-1:IDX_W], IDX_W'(0)};
         end
         if (state_q == ST_ISSUE) begin
            cnt_q <= cnt_q + IDX_W'(1);
         end
         if (((state_q == ST_ISSUE) || (state_q == ST_DRAIN)) && !granted_ready) begin
            abort_q <= 1'b1;
         end
         if (ret_tag.vld) begin
            if (ret_tag.port == ACC_32) begin
               s_data_q <= i_bram_dout;
            end else begin
               w_data_q[ret_tag.idx] <= i_bram_dout;
            end
         end
      end
   end

endmodule

// File: tb/tb_bram_rd_ctrl.sv
// Directed bench: instance 0 uses a 2-cycle BRAM, instance 1 a 4-cycle BRAM.
module tb_bram_rd_ctrl;

   localparam int AW = 13;

   logic clk  = 1'b0;
   logic rstn = 1'b0;
   always #5 clk = ~clk;

   logic          s_acc     [2];
   logic [AW-1:0] s_addr    [2];
   logic          s_ready   [2];
   logic          s_valid   [2];
   logic [31:0]   s_data    [2];
   logic [AW-1:0] w_addr    [2];
   logic          w_ready   [2];
   logic          w_valid   [2];
   logic [511:0]  w_data    [2];
   logic          bram_en   [2];
   logic [AW-1:0] bram_addr [2];

   int checks   = 0;
   int failures = 0;

   function automatic logic [31:0] mem_word(input logic [AW-1:0] a);
      if (a == 13'h0123) return 32'hDEADBEEF;
      if (a == 13'h1FFF) return 32'hCAFEF00D;
      return {19'h0, a};
   endfunction

   for (genvar gi = 0; gi < 2; gi++) begin : g_inst
      localparam int LAT = (gi == 0) ? 2 : 4;
      logic [31:0] pipe_q [LAT];
      logic [31:0] dout;

      always_ff @(posedge clk) begin
         pipe_q[0] <= bram_en[gi] ? mem_word(bram_addr[gi]) : 32'h0;
         for (int k = 1; k < LAT; k++) pipe_q[k] <= pipe_q[k-1];
      end
      assign dout = pipe_q[LAT-1];

      bram_rd_ctrl #(
         .RD_LAT (LAT),
         .AW     (AW)
      ) u_dut (
         .i_clk             (clk),
         .i_rstn            (rstn),
         .i_s_access_type   (s_acc[gi]),
         .i_s_rd_addr       (s_addr[gi]),
         .i_s_rd_addr_ready (s_ready[gi]),
         .o_s_data_valid    (s_valid[gi]),
         .o_s_data          (s_data[gi]),
         .i_w_rd_addr       (w_addr[gi]),
         .i_w_rd_addr_ready (w_ready[gi]),
         .o_w_data_valid    (w_valid[gi]),
         .o_w_data          (w_data[gi]),
         .o_bram_en         (bram_en[gi]),
         .o_bram_addr       (bram_addr[gi]),
         .i_bram_dout       (dout)
      );
   end

   function automatic bit outputs_zero(input int i);
      return (bram_en[i] === 1'b0) && (bram_addr[i] === '0) && (s_valid[i] === 1'b0) &&
             (w_valid[i] === 1'b0) && (s_data[i] === '0) && (w_data[i] === '0);
   endfunction

   // 32b read: latency, single enable pulse, data, hold, release.
   task automatic run_s(input int inst, input logic [AW-1:0] addr,
                        input logic [31:0] exp_data, input int exp_lat);
      int n = 0; int en_cnt = 0; bit got = 0; bit w_seen = 0; bit stable = 1;
      logic [AW-1:0] en_addr = '0;
      s_addr[inst]  = addr;
      s_ready[inst] = 1'b1;
      while (!got && n < 80) begin
         @(posedge clk); #1; n++;
         if (bram_en[inst]) begin en_cnt++; en_addr = bram_addr[inst]; end
         if (w_valid[inst]) w_seen = 1;
         if (n == 1) s_addr[inst] = ~addr;
         if (s_valid[inst]) got = 1;
      end
      checks++;
      if (!got || n != exp_lat) begin
         failures++;
         $display("FAIL s_latency inst=%0d got_valid=%0d cycle=%0d expected=%0d", inst, got, n, exp_lat);
      end
      checks++;
      if (en_cnt != 1 || en_addr !== addr) begin
         failures++;
         $display("FAIL s_bram inst=%0d pulses=%0d addr=%h expected 1 pulse addr=%h", inst, en_cnt, en_addr, addr);
      end
      checks++;
      if (s_data[inst] !== exp_data) begin
         failures++;
         $display("FAIL s_data inst=%0d got=%h expected=%h", inst, s_data[inst], exp_data);
      end
      for (int c = 0; c < 3; c++) begin
         @(posedge clk); #1;
         if (s_valid[inst] !== 1'b1 || s_data[inst] !== exp_data) stable = 0;
         if (w_valid[inst]) w_seen = 1;
      end
      checks++;
      if (!stable) begin
         failures++;
         $display("FAIL s_hold inst=%0d valid=%b data=%h expected valid=1 data=%h", inst, s_valid[inst], s_data[inst], exp_data);
      end
      s_ready[inst] = 1'b0;
      @(posedge clk); #1;
      checks++;
      if (s_valid[inst] !== 1'b0) begin
         failures++;
         $display("FAIL s_clear inst=%0d valid=%b expected=0", inst, s_valid[inst]);
      end
      checks++;
      if (w_seen) begin
         failures++;
         $display("FAIL s_other_valid inst=%0d w_valid seen=1 expected=0", inst);
      end
      $display("txn 32b inst=%0d addr=%h data=%h latency=%0d", inst, addr, s_data[inst], n);
   endtask

   // 512b read: 16 gapless enables, assembled line, latency, hold, release.
   task automatic run_w(input int inst, input logic [AW-1:0] addr, input int exp_lat);
      int n = 0; int en_cnt = 0; bit got = 0; bit s_seen = 0; bit en_bad = 0; bit stable = 1;
      logic [AW-1:0]  base = {addr[AW-1:4], 4'h0};
      logic [AW-1:0]  ea;
      logic [511:0]   exp_line;
      for (int k = 0; k < 16; k++) exp_line[32*k +: 32] = mem_word(base + AW'(k));
      w_addr[inst]  = addr;
      w_ready[inst] = 1'b1;
      while (!got && n < 100) begin
         @(posedge clk); #1; n++;
         if (bram_en[inst]) begin
            en_cnt++;
            ea = base + AW'(n - 1);
            if (en_cnt != n || bram_addr[inst] !== ea) en_bad = 1;
         end
         if (s_valid[inst]) s_seen = 1;
         if (n == 1) w_addr[inst] = ~addr;
         if (w_valid[inst]) got = 1;
      end
      checks++;
      if (!got || n != exp_lat) begin
         failures++;
         $display("FAIL w_latency inst=%0d got_valid=%0d cycle=%0d expected=%0d", inst, got, n, exp_lat);
      end
      checks++;
      if (en_cnt != 16 || en_bad) begin
         failures++;
         $display("FAIL w_bram inst=%0d pulses=%0d bad_addr_or_gap=%0d expected 16 consecutive from %h", inst, en_cnt, en_bad, base);
      end
      checks++;
      if (w_data[inst] !== exp_line) begin
         failures++;
         $display("FAIL w_data inst=%0d word0=%h word15=%h expected word0=%h word15=%h", inst,
                  w_data[inst][31:0], w_data[inst][511:480], exp_line[31:0], exp_line[511:480]);
      end
      for (int c = 0; c < 3; c++) begin
         @(posedge clk); #1;
         if (w_valid[inst] !== 1'b1 || w_data[inst] !== exp_line) stable = 0;
         if (s_valid[inst]) s_seen = 1;
      end
      checks++;
      if (!stable) begin
         failures++;
         $display("FAIL w_hold inst=%0d valid=%b expected valid=1 with stable data", inst, w_valid[inst]);
      end
      w_ready[inst] = 1'b0;
      @(posedge clk); #1;
      checks++;
      if (w_valid[inst] !== 1'b0) begin
         failures++;
         $display("FAIL w_clear inst=%0d valid=%b expected=0", inst, w_valid[inst]);
      end
      checks++;
      if (s_seen) begin
         failures++;
         $display("FAIL w_other_valid inst=%0d s_valid seen=1 expected=0", inst);
      end
      $display("txn 512b inst=%0d addr=%h word0=%h latency=%0d", inst, addr, w_data[inst][31:0], n);
   endtask

   task automatic test_reset();
      #1;
      for (int i = 0; i < 2; i++) begin
         checks++;
         if (!outputs_zero(i)) begin
            failures++;
            $display("FAIL reset_outputs inst=%0d en=%b addr=%h s_valid=%b w_valid=%b s_data=%h expected all 0",
                     i, bram_en[i], bram_addr[i], s_valid[i], w_valid[i], s_data[i]);
         end
      end
      @(negedge clk); rstn = 1'b1;
      @(posedge clk); #1;
      for (int i = 0; i < 2; i++) begin
         checks++;
         if (!outputs_zero(i)) begin
            failures++;
            $display("FAIL idle_outputs inst=%0d en=%b s_valid=%b w_valid=%b expected all 0", i, bram_en[i], s_valid[i], w_valid[i]);
         end
      end
      $display("txn reset released");
   endtask

   // Both requesters high: 32b first after reset, 512b next, then 32b again.
   task automatic test_arbitration();
      for (int round = 0; round < 2; round++) begin
         int n = 0; bit s_got = 0; bit w_got = 0; bit s_again = 0;
         s_addr[0] = 13'h0010; w_addr[0] = 13'h0080;
         s_ready[0] = 1'b1; w_ready[0] = 1'b1;
         while (!s_got && !w_got && n < 60) begin
            @(posedge clk); #1; n++;
            s_got = s_valid[0]; w_got = w_valid[0];
         end
         checks++;
         if (!s_got || w_got || n != 4) begin
            failures++;
            $display("FAIL arb_first round=%0d s_valid=%b w_valid=%b cycle=%0d expected 32b valid alone at 4", round, s_got, w_got, n);
         end
         checks++;
         if (s_data[0] !== 32'h0000_0010) begin
            failures++;
            $display("FAIL arb_s_data round=%0d got=%h expected=00000010", round, s_data[0]);
         end
         s_ready[0] = 1'b0;
         n = 0;
         while (!w_got && n < 60) begin
            @(posedge clk); #1; n++;
            w_got = w_valid[0];
            if (s_valid[0] && n > 1) s_again = 1;
         end
         checks++;
         if (!w_got || s_again || w_data[0][31:0] !== 32'h80 || w_data[0][511:480] !== 32'h8F) begin
            failures++;
            $display("FAIL arb_second round=%0d w_valid=%b s_valid_seen=%b word0=%h word15=%h expected 1 0 00000080 0000008f",
                     round, w_got, s_again, w_data[0][31:0], w_data[0][511:480]);
         end
         w_ready[0] = 1'b0;
         @(posedge clk); #1;
         $display("txn arbitration round=%0d served 32b then 512b", round);
      end
   endtask

   task automatic test_read32();
      run_s(0, 13'h0123, 32'hDEADBEEF, 4);
   endtask

   task automatic test_read512();
      run_w(0, 13'h0047, 19);
   endtask

   // 32b ready dropped mid-transaction, then a 512b request from cycle 4.
   task automatic test_ready_drop();
      int n = 0; int en_cnt = 0; bit seen = 0;
      s_addr[0]  = 13'h0055;
      s_ready[0] = 1'b1;
      while (n < 4) begin
         @(posedge clk); #1; n++;
         if (bram_en[0]) en_cnt++;
         if (s_valid[0]) seen = 1;
         if (n == 2) s_ready[0] = 1'b0;
      end
      checks++;
      if (en_cnt != 1) begin
         failures++;
         $display("FAIL drop_pulse pulses=%0d expected=1", en_cnt);
      end
      checks++;
      if (seen) begin
         failures++;
         $display("FAIL drop_valid s_valid seen=1 expected=0");
      end
      $display("txn 32b dropped pulses=%0d", en_cnt);
      run_w(0, 13'h0047, 19);
   endtask

   // Reset while word 8 of a 512b read is issued; stale BRAM data must not land.
   task automatic test_reset_mid();
      int n = 0; bit hit = 0;
      w_addr[0]  = 13'h0047;
      w_ready[0] = 1'b1;
      while (!hit && n < 40) begin
         @(posedge clk); #1; n++;
         if (bram_en[0] && bram_addr[0] === 13'h0048) hit = 1;
      end
      checks++;
      if (!hit || n != 9) begin
         failures++;
         $display("FAIL rst_word8 reached=%0d cycle=%0d expected word 8 at cycle 9", hit, n);
      end
      rstn = 1'b0;
      w_ready[0] = 1'b0;
      #1;
      checks++;
      if (!outputs_zero(0)) begin
         failures++;
         $display("FAIL rst_mid_outputs en=%b addr=%h s_data=%h w_valid=%b expected all 0", bram_en[0], bram_addr[0], s_data[0], w_valid[0]);
      end
      #2; rstn = 1'b1;
      @(posedge clk); #1;
      $display("txn reset during 512b word 8");
      run_s(0, 13'h1FFF, 32'hCAFEF00D, 4);
      checks++;
      if (w_data[0] !== '0) begin
         failures++;
         $display("FAIL rst_stale_w word7=%h word8=%h expected 0", w_data[0][255:224], w_data[0][287:256]);
      end
   endtask

   task automatic test_lat4();
      run_s(1, 13'h0123, 32'hDEADBEEF, 6);
      run_w(1, 13'h0047, 21);
   endtask

   initial begin
      for (int i = 0; i < 2; i++) begin
         s_acc[i] = 1'b1; s_addr[i] = '0; s_ready[i] = 1'b0;
         w_addr[i] = '0; w_ready[i] = 1'b0;
      end
      test_reset();
      test_arbitration();
      test_read32();
      test_read512();
      test_ready_drop();
      test_reset_mid();
      test_lat4();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
